// File: rtl/vram_pkg.sv
// vram_pkg: shared types and decode constants for the CPU-side video RAM port.
// FSM states and the 1 KB window bases for screen and character RAM.
package vram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        ACCESS,
        DONE
    } state_e;

    localparam logic [5:0] SCR_BASE0 = 6'b001000;
    localparam logic [5:0] SCR_BASE1 = 6'b001001;
    localparam logic [5:0] CHR_BASE0 = 6'b001010;
    localparam logic [5:0] CHR_BASE1 = 6'b001011;

endpackage

// File: rtl/vram_cpu_port_if.sv
// vram_cpu_port_if: Z80 memory-cycle bus between the CPU and the video RAM port.
// master = CPU side, slave = video RAM port side.
interface vram_cpu_port_if;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_mreq;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_sel;
    logic        cpu_wait;
    logic        cpu_rdy;

    modport master (
        output cpu_addr, cpu_dout, cpu_mreq, cpu_rd, cpu_wr,
        input  cpu_din, cpu_sel, cpu_wait, cpu_rdy
    );

    modport slave (
        input  cpu_addr, cpu_dout, cpu_mreq, cpu_rd, cpu_wr,
        output cpu_din, cpu_sel, cpu_wait, cpu_rdy
    );

endinterface

// File: rtl/vram_decode.sv
// vram_decode: maps address bits [15:10] onto the screen and character RAM
// windows; shared with the memory map.
module vram_decode
    import vram_pkg::*;
(
    input  logic [5:0] addr_hi,
    output logic       scr_hit,
    output logic       chr_hit
);

    assign scr_hit = (addr_hi == SCR_BASE0) | (addr_hi == SCR_BASE1);
    assign chr_hit = (addr_hi == CHR_BASE0) | (addr_hi == CHR_BASE1);

endmodule

// File: rtl/vram_cpu_port.sv
// vram_cpu_port: Z80 access port onto port B of the screen/char video RAMs.
// Optional VRAM_CONTENTION_EN holds accesses off until the beam is in blank.
module vram_cpu_port
    import vram_pkg::*;
#(
    parameter int         RD_LAT      = 1,
    parameter logic [7:0] CRAM_RD_VAL = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          hblank,
    input  logic          vblank,
    vram_cpu_port_if.slave cpu,
    output logic [9:0]    ram_addr,
    output logic [7:0]    ram_data,
    output logic          sram_we,
    output logic          cram_we,
    input  logic [7:0]    sram_q
);

    localparam logic [1:0] LAST = 2'(RD_LAT - 1);

    state_e     state_q;
    logic [9:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] din_q;
    logic [1:0] cnt_q;
    logic       rd_q;
    logic       chr_q;
    logic       swe_q;
    logic       cwe_q;

    logic scr_hit;
    logic chr_hit;
    logic req;
    logic rel;
    logic start;
    logic hold_req;
    logic hold_go;

    vram_decode u_decode (
        .addr_hi (cpu.cpu_addr[15:10]),
        .scr_hit (scr_hit),
        .chr_hit (chr_hit)
    );

    assign cpu.cpu_sel = cpu.cpu_mreq & (scr_hit | chr_hit);
    assign req   = cpu.cpu_sel & (cpu.cpu_rd | cpu.cpu_wr);
    assign rel   = ~cpu.cpu_mreq | ~(cpu.cpu_rd | cpu.cpu_wr);
    assign start = (state_q == IDLE) & req;

`ifdef VRAM_CONTENTION_EN
    logic disp;
    assign disp     = ~hblank & ~vblank;
    assign hold_req = disp;
    assign hold_go  = ~disp & ce_pix;
`else
    logic unused_ok;
    assign unused_ok = ^{ce_pix, hblank, vblank};
    assign hold_req  = 1'b0;
    assign hold_go   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            din_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            chr_q   <= 1'b0;
            swe_q   <= 1'b0;
            cwe_q   <= 1'b0;
        end else begin
            swe_q <= 1'b0;
            cwe_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q <= cpu.cpu_addr[9:0];
                        data_q <= cpu.cpu_dout;
                        rd_q   <= cpu.cpu_rd;
                        chr_q  <= chr_hit;
                        cnt_q  <= '0;
                        if (hold_req) begin
                            state_q <= HOLD;
                        end else begin
                            state_q <= ACCESS;
                            swe_q   <= ~cpu.cpu_rd & scr_hit;
                            cwe_q   <= ~cpu.cpu_rd & chr_hit;
                        end
                    end
                end
                HOLD: begin
                    if (rel) begin
                        state_q <= IDLE;
                    end else if (hold_go) begin
                        state_q <= ACCESS;
                        swe_q   <= ~rd_q & ~chr_q;
                        cwe_q   <= ~rd_q & chr_q;
                    end
                end
                ACCESS: begin
                    // An aborted cycle still finishes its RAM operation.
                    if (!rd_q || cnt_q == LAST) begin
                        if (rd_q) din_q <= chr_q ? CRAM_RD_VAL : sram_q;
                        state_q <= rel ? IDLE : DONE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    if (rel) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu.cpu_wait = start | (state_q == HOLD) | (state_q == ACCESS);
    assign cpu.cpu_rdy  = (state_q == DONE);
    assign cpu.cpu_din  = din_q;

    // Live address on the request clk lets the RAM read begin one clk early.
    assign ram_addr = start ? cpu.cpu_addr[9:0] : addr_q;
    assign ram_data = data_q;
    assign sram_we  = swe_q;
    assign cram_we  = cwe_q;

endmodule

// File: tb/tb_vram_cpu_port.sv
// tb_vram_cpu_port: vector table, corner sequences and randomized transactions
// checked against a transaction-level model of the video RAM port.
module tb_vram_cpu_port;

    localparam int RD_LAT = 1;
    localparam int BUDGET = 8;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       ce_pix  = 1'b0;
    logic       hblank  = 1'b1;
    logic       vblank  = 1'b0;
    logic       mem_clr = 1'b1;
    logic [9:0] ram_addr;
    logic [7:0] ram_data;
    logic [7:0] sram_q;
    logic       sram_we;
    logic       cram_we;
    int         ce_cnt  = 0;

    int n_chk  = 0;
    int n_pass = 0;

    vram_cpu_port_if bus ();

    vram_cpu_port #(
        .RD_LAT      (RD_LAT),
        .CRAM_RD_VAL (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce_pix   (ce_pix),
        .hblank   (hblank),
        .vblank   (vblank),
        .cpu      (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .sram_we  (sram_we),
        .cram_we  (cram_we),
        .sram_q   (sram_q)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        ce_cnt++;
        ce_pix = (ce_cnt % 3 == 0);
    end

    // Screen RAM port B with RD_LAT clks from sampled address to data out.
    logic [7:0] mem [1024];
    logic [7:0] qp  [RD_LAT];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (sram_we) begin
            mem[ram_addr] <= ram_data;
        end
        qp[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
    end
    assign sram_q = qp[RD_LAT-1];

    logic [7:0] mdl [1024];

    typedef struct {
        int         n_wait;
        int         n_swe;
        int         n_cwe;
        logic       sel;
        logic       rdy;
        logic       held;
        logic       idle;
        logic       addr_ok;
        logic       data_ok;
        logic [7:0] din;
    } res_t;

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [7:0]  data;
        logic        sel;
        int          wt;
        int          swe;
        int          cwe;
        logic [7:0]  din;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    endtask

    task automatic drive(input logic [15:0] a, input logic m,
                         input logic rd, input logic wr, input logic [7:0] d);
        bus.cpu_addr = a;
        bus.cpu_mreq = m;
        bus.cpu_rd   = rd;
        bus.cpu_wr   = wr;
        bus.cpu_dout = d;
    endtask

    task automatic run_txn(input logic [15:0] a, input logic rd,
                           input logic wr, input logic [7:0] d,
                           output res_t r);
        r.n_wait = 0; r.n_swe = 0; r.n_cwe = 0;
        r.sel = 1'b0; r.rdy = 1'b0; r.held = 1'b0; r.idle = 1'b0;
        r.addr_ok = 1'b1; r.data_ok = 1'b1; r.din = 8'h00;
        @(posedge clk); #1;
        drive(a, 1'b1, rd, wr, d);
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (i == 0) r.sel = bus.cpu_sel;
            if (bus.cpu_wait) r.n_wait++;
            if (sram_we || cram_we) begin
                if (sram_we) r.n_swe++;
                if (cram_we) r.n_cwe++;
                if (ram_addr !== a[9:0]) r.addr_ok = 1'b0;
                if (ram_data !== d) r.data_ok = 1'b0;
            end
            if (bus.cpu_rdy) begin
                r.rdy = 1'b1;
                r.din = bus.cpu_din;
                if (ram_addr !== a[9:0]) r.addr_ok = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        drive(a, 1'b0, 1'b0, 1'b0, d);
        @(negedge clk);
        r.held = bus.cpu_rdy;
        @(negedge clk);
        r.idle = !bus.cpu_rdy && !bus.cpu_wait;
    endtask

    task automatic cmp_txn(input string t, input res_t r, input logic sel,
                           input int wt, input int swe, input int cwe,
                           input logic rd_chk, input logic [7:0] din);
        check({t, "_sel"}, r.sel, sel);
        check({t, "_wait"}, r.n_wait, wt);
        check({t, "_swe"}, r.n_swe, swe);
        check({t, "_cwe"}, r.n_cwe, cwe);
        check({t, "_rdy"}, r.rdy, wt != 0);
        check({t, "_hold_rdy"}, r.held, wt != 0);
        check({t, "_idle"}, r.idle, 1'b1);
        check({t, "_addr"}, r.addr_ok, 1'b1);
        check({t, "_data"}, r.data_ok, 1'b1);
        if (rd_chk) check({t, "_din"}, r.din, din);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [11];
        res_t r;

        for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        @(negedge clk);
        check("rst_wait", bus.cpu_wait, 1'b0);
        check("rst_rdy", bus.cpu_rdy, 1'b0);
        check("rst_swe", sram_we, 1'b0);
        check("rst_cwe", cram_we, 1'b0);
        check("rst_din", bus.cpu_din, 8'h00);
        check("rst_addr", ram_addr, 10'h000);
        check("rst_data", ram_data, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;

        //         addr      rd    wr    data   sel wt swe cwe din
        vt[0]  = '{16'h2405, 1'b0, 1'b1, 8'h41, 1, 2, 1, 0, 8'h00};
        vt[1]  = '{16'h2405, 1'b1, 1'b0, 8'h00, 1, 2, 0, 0, 8'h41};
        vt[2]  = '{16'h2C10, 1'b1, 1'b0, 8'h00, 1, 2, 0, 0, 8'hFF};
        vt[3]  = '{16'h2800, 1'b0, 1'b1, 8'h5A, 1, 2, 0, 1, 8'h00};
        vt[4]  = '{16'h23FF, 1'b0, 1'b1, 8'h99, 1, 2, 1, 0, 8'h00};
        vt[5]  = '{16'h23FF, 1'b1, 1'b0, 8'h00, 1, 2, 0, 0, 8'h99};
        vt[6]  = '{16'h3000, 1'b1, 1'b0, 8'h00, 0, 0, 0, 0, 8'h00};
        vt[7]  = '{16'h2405, 1'b1, 1'b1, 8'h77, 1, 2, 0, 0, 8'h41};
        vt[8]  = '{16'h1FFF, 1'b0, 1'b1, 8'h12, 0, 0, 0, 0, 8'h00};
        vt[9]  = '{16'h2FFF, 1'b1, 1'b0, 8'h00, 1, 2, 0, 0, 8'hFF};
        vt[10] = '{16'h2000, 1'b1, 1'b0, 8'h00, 1, 2, 0, 0, 8'h00};

        for (int i = 0; i < 11; i++) begin
            run_txn(vt[i].addr, vt[i].rd, vt[i].wr, vt[i].data, r);
            cmp_txn($sformatf("vec%0d", i), r, vt[i].sel, vt[i].wt,
                    vt[i].swe, vt[i].cwe, vt[i].rd, vt[i].din);
            if (vt[i].sel && vt[i].wr && !vt[i].rd && vt[i].addr < 16'h2800)
                mdl[vt[i].addr[9:0]] = vt[i].data;
        end

        // Write aborted while in ACCESS: pulse completes, no rdy.
        @(posedge clk); #1;
        drive(16'h2001, 1'b1, 1'b0, 1'b1, 8'h33);
        @(posedge clk); #1;
        drive(16'h2001, 1'b1, 1'b0, 1'b0, 8'h33);
        @(negedge clk);
        check("abort_we", sram_we, 1'b1);
        check("abort_wait", bus.cpu_wait, 1'b1);
        @(negedge clk);
        check("abort_rdy", bus.cpu_rdy, 1'b0);
        check("abort_idle", bus.cpu_wait, 1'b0);
        mdl[1] = 8'h33;
        run_txn(16'h2001, 1'b1, 1'b0, 8'h00, r);
        cmp_txn("abort_rb", r, 1'b1, RD_LAT + 1, 0, 0, 1'b1, 8'h33);

        // Reset asserted while a read is in ACCESS.
        @(posedge clk); #1;
        drive(16'h2402, 1'b1, 1'b1, 1'b0, 8'hA5);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(16'h2402, 1'b0, 1'b0, 1'b0, 8'hA5);
        @(negedge clk);
        check("acc_wait", bus.cpu_wait, 1'b1);
        @(negedge clk);
        check("rst2_wait", bus.cpu_wait, 1'b0);
        check("rst2_rdy", bus.cpu_rdy, 1'b0);
        check("rst2_we", {sram_we, cram_we}, 2'b00);
        check("rst2_din", bus.cpu_din, 8'h00);
        check("rst2_addr", ram_addr, 10'h000);
        check("rst2_data", ram_data, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;

`ifdef VRAM_CONTENTION_EN
        begin
            int nw;
            int ns;
            int k_exp;
            int k_got;
            int npulse;
            hblank = 1'b0;
            vblank = 1'b0;
            @(posedge clk); #1;
            drive(16'h2800, 1'b1, 1'b0, 1'b1, 8'hC3);
            nw = 0;
            ns = 0;
            repeat (50) begin
                @(negedge clk);
                if (bus.cpu_wait) nw++;
                if (sram_we || cram_we) ns++;
            end
            check("hold_wait", nw, 50);
            check("hold_strobe", ns, 0);
            @(posedge clk); #1;
            hblank = 1'b1;
            k_exp = -1;
            k_got = -1;
            npulse = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (cram_we) begin
                    npulse++;
                    if (k_got < 0) k_got = k;
                    check("rel_addr", ram_addr, 10'h000);
                end
                if (k_exp < 0 && ce_pix && hblank) k_exp = k + 1;
            end
            check("rel_cycle", k_got, k_exp);
            check("rel_pulses", npulse, 1);
            check("rel_rdy", bus.cpu_rdy, 1'b1);
            @(posedge clk); #1;
            drive(16'h2800, 1'b0, 1'b0, 1'b0, 8'hC3);
            repeat (2) @(negedge clk);
            check("rel_idle", bus.cpu_rdy | bus.cpu_wait, 1'b0);

            hblank = 1'b0;
            @(posedge clk); #1;
            drive(16'h2C00, 1'b1, 1'b0, 1'b1, 8'h11);
            ns = 0;
            repeat (5) begin
                @(negedge clk);
                if (sram_we || cram_we) ns++;
            end
            @(posedge clk); #1;
            drive(16'h2C00, 1'b1, 1'b0, 1'b0, 8'h11);
            @(negedge clk);
            @(negedge clk);
            check("hab_wait", bus.cpu_wait, 1'b0);
            check("hab_rdy", bus.cpu_rdy, 1'b0);
            hblank = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (sram_we || cram_we) ns++;
            end
            check("hab_strobe", ns, 0);
            drive(16'h2C00, 1'b0, 1'b0, 1'b0, 8'h11);
        end
`else
        hblank = 1'b0;
        vblank = 1'b0;
        run_txn(16'h2800, 1'b0, 1'b1, 8'hC3, r);
        cmp_txn("nodisp", r, 1'b1, 2, 0, 1, 1'b0, 8'h00);
        hblank = 1'b1;
`endif

        for (int n = 0; n < 150; n++) begin
            logic [15:0] a;
            logic        rd;
            logic        wr;
            logic [7:0]  d;
            int          op;
            logic        sel;
            logic        acc;
            logic        scr;
            if ($urandom_range(0, 9) < 8) a = 16'h2000 + 16'($urandom_range(0, 16'hFFF));
            else a = 16'($urandom);
            op = $urandom_range(0, 4);
            rd = (op == 0) || (op == 2);
            wr = (op == 1) || (op == 2) || (op == 4);
            d  = 8'($urandom);
`ifndef VRAM_CONTENTION_EN
            hblank = 1'($urandom);
            vblank = 1'($urandom);
`endif
            sel = (a >= 16'h2000) && (a < 16'h3000);
            acc = sel && (rd || wr);
            scr = a < 16'h2800;
            run_txn(a, rd, wr, d, r);
            cmp_txn($sformatf("rnd%0d", n), r, sel,
                    acc ? (rd ? RD_LAT + 1 : 2) : 0,
                    (acc && !rd && scr) ? 1 : 0,
                    (acc && !rd && !scr) ? 1 : 0,
                    acc && rd, scr ? mdl[a % 1024] : 8'hFF);
            if (acc && !rd && scr) mdl[a % 1024] = d;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vram_cpu_port.md
Name: vram_cpu_port

Overview:
- CPU-side access port to the dual-port screen RAM (1 KB) and character RAM (1 KB); the display generator reads the other RAM port.
- Decodes Z80 memory cycles and drives RAM port B.
- Holds the CPU in WAIT while the access is pending. With contention enabled, a pending access is also held off until the beam leaves the active display area.

Parameters:
- RD_LAT, 1, RAM port-B read latency in clk cycles (1..3).
- CRAM_RD_VAL, 8'hFF, value returned on reads of write-only character RAM.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_pix  in  1  pixel clock enable, same strobe the display generator uses
- hblank  in  1  horizontal blank from the display generator
- vblank  in  1  vertical blank from the display generator
- cpu_addr  in  16  Z80 address
- cpu_dout  in  8  Z80 write data
- cpu_din  out  8  read data to Z80, valid while cpu_rdy
- cpu_mreq  in  1  Z80 MREQ, active-high
- cpu_rd  in  1  Z80 RD, active-high
- cpu_wr  in  1  Z80 WR, active-high
- cpu_sel  out  1  combinational: address decodes to video RAM
- cpu_wait  out  1  WAIT request to Z80
- cpu_rdy  out  1  access complete; held until strobes drop
- ram_addr  out  10  port-B address
- ram_data  out  8  port-B write data
- sram_we  out  1  screen RAM write strobe, 1 clk
- cram_we  out  1  char RAM write strobe, 1 clk
- sram_q  in  8  screen RAM port-B read data

Behaviour:
- Decode on cpu_addr[15:10]:
  - 6'b001000 and 6'b001001 (0x2000/0x2400) select screen RAM.
  - 6'b001010 and 6'b001011 (0x2800/0x2C00) select char RAM.
  - cpu_sel = mreq & (either range).
- req = cpu_sel & (cpu_rd | cpu_wr). An access starts on the first clk where req=1 in IDLE; address, data, direction and target are latched at that point.
- Signal "disp" = ~hblank & ~vblank, sampled every clk.
- State machine:
  - IDLE: on req, go to HOLD if contention is enabled and disp=1; otherwise go to ACCESS. cpu_wait rises combinationally with req in IDLE.
  - HOLD: cpu_wait=1. Go to ACCESS on the first clk with disp=0.
  - ACCESS: cpu_wait=1. A write pulses sram_we or cram_we for exactly 1 clk, then goes to DONE. A read counts RD_LAT clks, latches cpu_din (sram_q for screen RAM, CRAM_RD_VAL for char RAM), then goes to DONE.
  - DONE: cpu_wait=0, cpu_rdy=1, cpu_din stable. Return to IDLE when cpu_rd and cpu_wr are both 0 or cpu_mreq=0. A new access is never started from DONE.
- Total latency with no contention:
  - Write: 1 clk in ACCESS plus 1 clk to DONE.
  - Read: RD_LAT+1 clks.
- Boundary conditions:
  - Strobes dropping during HOLD or ACCESS (aborted cycle): HOLD returns to IDLE with no RAM strobe issued. ACCESS completes its write pulse or read, then returns to IDLE.
  - cpu_rd and cpu_wr both high: treated as a read.
  - disp rising while in ACCESS: ignored; the access completes.
  - Blank edge coinciding with req: the disp value sampled that clk decides.
  - ram_addr = latched cpu_addr[9:0]. It is held through ACCESS and DONE.
- Reset: state IDLE, cpu_wait=0, cpu_rdy=0, sram_we=0, cram_we=0, cpu_din=0, ram_addr=0, ram_data=0.
- ce_pix is unused unless the optional feature is enabled.

Optional Feature:
- VRAM_CONTENTION_EN defined:
  - HOLD is used, as above.
  - Exit from HOLD additionally requires ce_pix=1 on the same clk, so release aligns to pixel timing.
- Undefined:
  - HOLD is unreachable and the state is optimised out.
  - IDLE goes directly to ACCESS regardless of disp.
  - hblank, vblank and ce_pix are unused.

Decomposition:
- Package vram_pkg:
  - state enum (IDLE, HOLD, ACCESS, DONE);
  - decode constants SCR_BASE0=6'b001000, SCR_BASE1=6'b001001, CHR_BASE0=6'b001010, CHR_BASE1=6'b001011.
- Sub-module vram_decode: combinational address decoder producing scr_hit and chr_hit; reused by the memory map.

Test Plan:
- Write 8'h41 to 0x2405 with disp=0 -> sram_we pulses 1 clk with ram_addr=10'h005 and ram_data=8'h41; cpu_wait=1 for 2 clks; cpu_rdy=1 until cpu_wr drops.
- Read 0x2405 with RAM holding 8'h41 and RD_LAT=1 -> cpu_din=8'h41 in DONE; no we pulse.
- Read 0x2C10 -> cpu_din=8'hFF; cram_we=0 throughout.
- With VRAM_CONTENTION_EN, write 0x2800 while disp=1 for 50 clks -> cpu_wait held for 50 clks, no strobe; cram_we pulses on the first clk with disp=0 and ce_pix=1.
- Drop cpu_wr during HOLD -> state returns to IDLE, no write strobe, cpu_wait=0.
- Access 0x3000 -> cpu_sel=0, cpu_wait=0, no RAM activity. Assert reset during ACCESS -> all outputs at reset values next clk.
